// File: rtl/bsg_miniblade_tag_serial_driver_pkg.sv
// Shared types and elaboration helpers for the bsg_tag serial driver.
package bsg_miniblade_tag_serial_driver_pkg;

  typedef enum logic [0:0] {
    e_tag_op_packet       = 1'b0,
    e_tag_op_master_reset = 1'b1
  } bsg_miniblade_tag_op_e;

  typedef enum logic [2:0] {
    e_idle,
    e_ones,
    e_start,
    e_node,
    e_dnr,
    e_len,
    e_payload,
    e_gap
  } bsg_miniblade_tag_state_e;

  // Width of an index that must be at least one bit even for trivial sizes.
  function automatic int safe_clog2(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bsg_miniblade_tag_serial_driver_if.sv
// Command handshake between a bsg_tag command source and the serial driver.
interface bsg_miniblade_tag_serial_driver_if
  import bsg_miniblade_tag_serial_driver_pkg::*;
#(
   parameter int tag_els_p      = 1024,
   parameter int tag_lg_width_p = 4
);
   localparam int lg_tag_els_lp = safe_clog2(tag_els_p);
   localparam int payload_w_lp  = (1 << tag_lg_width_p) - 1;

   logic                      v_i;
   logic                      ready_o;
   bsg_miniblade_tag_op_e     op_i;
   logic [lg_tag_els_lp-1:0]  node_id_i;
   logic                      data_not_reset_i;
   logic [tag_lg_width_p-1:0] len_i;
   logic [payload_w_lp-1:0]   payload_i;

   modport master (
      output v_i, op_i, node_id_i, data_not_reset_i, len_i, payload_i,
      input  ready_o
   );

   modport slave (
      input  v_i, op_i, node_id_i, data_not_reset_i, len_i, payload_i,
      output ready_o
   );
endinterface

// File: rtl/bsg_miniblade_tag_serial_driver_shifter.sv
// Loadable LSB-first shift register with a count of bits still to be shifted out.
module bsg_miniblade_tag_serial_driver_shifter #(
   parameter int width_p = 15,
   parameter int cnt_w_p = 6
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic               load_i,
   input  logic [width_p-1:0] data_i,
   input  logic [cnt_w_p-1:0] count_i,
   input  logic               shift_i,
   output logic               bit_o,
   output logic               empty_o
);
   logic [width_p-1:0] data_r;
   logic [cnt_w_p-1:0] cnt_r;

   assign bit_o   = data_r[0];
   assign empty_o = (cnt_r == '0);

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         cnt_r <= '0;
      end else if (load_i) begin
         cnt_r <= count_i;
      end else if (shift_i && !empty_o) begin
         cnt_r <= cnt_r - cnt_w_p'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (load_i) begin
         data_r <= data_i;
      end else if (shift_i && !empty_o) begin
         data_r <= data_r >> 1;
      end
   end
endmodule

// File: rtl/bsg_miniblade_tag_serial_driver.sv
// Serializes parallel bsg_tag commands into the one-bit tag stream (tag clock domain).
// Define BSG_MINIBLADE_TAG_DRV_GAP_EN to follow every command with min_gap_p idle zeros.
module bsg_miniblade_tag_serial_driver
  import bsg_miniblade_tag_serial_driver_pkg::*;
#(
   parameter int tag_els_p      = 1024,
   parameter int tag_lg_width_p = 4,
   parameter int reset_ones_p   = 32,
   parameter int min_gap_p      = 2
) (
   input  logic                               clk_i,
   input  logic                               reset_n_i,
   bsg_miniblade_tag_serial_driver_if.slave   cmd,
   output logic                               tag_data_o,
   output logic                               busy_o
);
   localparam int lg_tag_els_lp = safe_clog2(tag_els_p);
   localparam int payload_w_lp  = (1 << tag_lg_width_p) - 1;
   localparam int shift_w_lp    = max2(max2(lg_tag_els_lp, tag_lg_width_p), payload_w_lp);
   localparam int cnt_max_lp    = max2(max2(reset_ones_p, lg_tag_els_lp),
                                       max2(1 << tag_lg_width_p, min_gap_p));
   localparam int cnt_w_lp      = safe_clog2(cnt_max_lp + 1);

   bsg_miniblade_tag_state_e   state_r;
   logic [cnt_w_lp-1:0]        cnt_r;
   logic                       out_of_reset_r;
   logic [lg_tag_els_lp-1:0]   node_r;
   logic                       dnr_r;
   logic [tag_lg_width_p-1:0]  len_r;
   logic [payload_w_lp-1:0]    payload_r;

   logic                       accept;
   logic                       last_bit;
   logic                       sh_load, sh_shift, sh_bit, sh_empty;
   logic [shift_w_lp-1:0]      sh_data;
   logic [cnt_w_lp-1:0]        sh_count;

   assign cmd.ready_o = out_of_reset_r && (state_r == e_idle);
   assign accept      = cmd.v_i && cmd.ready_o;
   assign busy_o      = (state_r != e_idle);

   // The state names the bit currently on tag_data_o; this flags its final bit.
   assign last_bit = ((state_r == e_ones) && (cnt_r == '0))
                  || ((state_r == e_payload) && sh_empty)
                  || ((state_r == e_len) && sh_empty && (len_r == '0));

   // Each field's bit 0 goes straight to the output; the shifter holds the rest.
   always_comb begin
      sh_load  = 1'b0;
      sh_shift = 1'b0;
      sh_data  = '0;
      sh_count = '0;
      unique case (state_r)
         e_start: begin
            sh_load  = 1'b1;
            sh_data  = shift_w_lp'(node_r >> 1);
            sh_count = cnt_w_lp'(lg_tag_els_lp - 1);
         end
         e_dnr: begin
            sh_load  = 1'b1;
            sh_data  = shift_w_lp'(len_r >> 1);
            sh_count = cnt_w_lp'(tag_lg_width_p - 1);
         end
         e_node, e_payload: sh_shift = !sh_empty;
         e_len: begin
            sh_shift = !sh_empty;
            if (sh_empty && (len_r != '0)) begin
               sh_load  = 1'b1;
               sh_data  = shift_w_lp'(payload_r >> 1);
               sh_count = cnt_w_lp'(len_r) - cnt_w_lp'(1);
            end
         end
         default: ;
      endcase
   end

   bsg_miniblade_tag_serial_driver_shifter #(
      .width_p (shift_w_lp),
      .cnt_w_p (cnt_w_lp)
   ) shifter (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .load_i    (sh_load),
      .data_i    (sh_data),
      .count_i   (sh_count),
      .shift_i   (sh_shift),
      .bit_o     (sh_bit),
      .empty_o   (sh_empty)
   );

   always_ff @(posedge clk_i) begin
      if (accept) begin
         node_r    <= cmd.node_id_i;
         dnr_r     <= cmd.data_not_reset_i;
         len_r     <= cmd.len_i;
         payload_r <= cmd.payload_i;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r        <= e_idle;
         cnt_r          <= '0;
         tag_data_o     <= 1'b0;
         out_of_reset_r <= 1'b0;
      end else begin
         out_of_reset_r <= 1'b1;
         if (last_bit) begin
            tag_data_o <= 1'b0;
`ifdef BSG_MINIBLADE_TAG_DRV_GAP_EN
            if (min_gap_p > 0) begin
               state_r <= e_gap;
               cnt_r   <= cnt_w_lp'(min_gap_p - 1);
            end else begin
               state_r <= e_idle;
            end
`else
            state_r <= e_idle;
`endif
         end else begin
            unique case (state_r)
               e_idle: begin
                  tag_data_o <= accept;
                  if (accept) begin
                     if (cmd.op_i == e_tag_op_master_reset) begin
                        state_r <= e_ones;
                        cnt_r   <= cnt_w_lp'(reset_ones_p - 1);
                     end else begin
                        state_r <= e_start;
                     end
                  end
               end
               e_ones: begin
                  tag_data_o <= 1'b1;
                  cnt_r      <= cnt_r - cnt_w_lp'(1);
               end
               e_start: begin
                  tag_data_o <= node_r[0];
                  state_r    <= e_node;
               end
               e_node: begin
                  if (!sh_empty) begin
                     tag_data_o <= sh_bit;
                  end else begin
                     tag_data_o <= dnr_r;
                     state_r    <= e_dnr;
                  end
               end
               e_dnr: begin
                  tag_data_o <= len_r[0];
                  state_r    <= e_len;
               end
               e_len: begin
                  if (!sh_empty) begin
                     tag_data_o <= sh_bit;
                  end else begin
                     tag_data_o <= payload_r[0];
                     state_r    <= e_payload;
                  end
               end
               e_payload: tag_data_o <= sh_bit;
               e_gap: begin
                  tag_data_o <= 1'b0;
                  if (cnt_r != '0) cnt_r <= cnt_r - cnt_w_lp'(1);
                  else             state_r <= e_idle;
               end
               default: begin
                  tag_data_o <= 1'b0;
                  state_r    <= e_idle;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_bsg_miniblade_tag_serial_driver.sv
// Bench for bsg_miniblade_tag_serial_driver: bit-stream model plus literal stream checks.
module tb_bsg_miniblade_tag_serial_driver;
   import bsg_miniblade_tag_serial_driver_pkg::*;

   localparam int tag_els_p      = 1024;
   localparam int tag_lg_width_p = 4;
   localparam int reset_ones_p   = 32;
   localparam int min_gap_p      = 2;
   localparam int lg_els         = safe_clog2(tag_els_p);
   localparam int pw             = (1 << tag_lg_width_p) - 1;
`ifdef BSG_MINIBLADE_TAG_DRV_GAP_EN
   localparam int gap_c = min_gap_p;
`else
   localparam int gap_c = 0;
`endif
   localparam int hist_n = 4096;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic tag_data, busy;

   always #5 clk = ~clk;

   bsg_miniblade_tag_serial_driver_if #(
      .tag_els_p(tag_els_p), .tag_lg_width_p(tag_lg_width_p)
   ) cmd_if ();

   bsg_miniblade_tag_serial_driver #(
      .tag_els_p(tag_els_p), .tag_lg_width_p(tag_lg_width_p),
      .reset_ones_p(reset_ones_p), .min_gap_p(min_gap_p)
   ) dut (
      .clk_i(clk), .reset_n_i(reset_n), .cmd(cmd_if),
      .tag_data_o(tag_data), .busy_o(busy)
   );

   int checks = 0;
   int errors = 0;

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endfunction

   // Model: one queue entry per future wire cycle, built straight from the packet format.
   typedef struct packed { logic b; logic bsy; } ent_t;
   ent_t q[$];
   ent_t gq[$];
   bit   oor_m;

   function automatic void gen(input bit op, input logic [lg_els-1:0] node, input logic dnr,
                               input logic [tag_lg_width_p-1:0] len, input logic [pw-1:0] pay);
      gq.delete();
      if (op) begin
         for (int i = 0; i < reset_ones_p; i++) gq.push_back('{1'b1, 1'b1});
      end else begin
         gq.push_back('{1'b1, 1'b1});
         for (int i = 0; i < lg_els; i++) gq.push_back('{node[i], 1'b1});
         gq.push_back('{dnr, 1'b1});
         for (int i = 0; i < tag_lg_width_p; i++) gq.push_back('{len[i], 1'b1});
         for (int i = 0; i < int'(len); i++) gq.push_back('{pay[i], 1'b1});
      end
      for (int i = 0; i < gap_c; i++) gq.push_back('{1'b0, 1'b1});
   endfunction

   function automatic logic [63:0] pack_gq(input int n);
      logic [63:0] r = '0;
      for (int i = 0; i < n; i++) r = {r[62:0], gq[i].b};
      return r;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q.delete();
         oor_m = 1'b0;
      end else begin
         bit acc;
         acc = cmd_if.v_i && oor_m && (q.size() == 0);
         if (q.size() != 0) void'(q.pop_front());
         if (acc) begin
            gen(cmd_if.op_i == e_tag_op_master_reset, cmd_if.node_id_i, cmd_if.data_not_reset_i,
                cmd_if.len_i, cmd_if.payload_i);
            foreach (gq[i]) q.push_back(gq[i]);
         end
         oor_m = 1'b1;
      end
   end

   logic hist_tag [hist_n];
   logic hist_bsy [hist_n];
   int   cyc = 0;

   always @(negedge clk) begin
      logic e_tag, e_bsy, e_rdy;
      e_tag = (q.size() != 0) ? q[0].b : 1'b0;
      e_bsy = (q.size() != 0);
      e_rdy = oor_m && (q.size() == 0);
      chk("tag_data_o", 64'(tag_data), 64'(e_tag));
      chk("busy_o", 64'(busy), 64'(e_bsy));
      chk("ready_o", 64'(cmd_if.ready_o), 64'(e_rdy));
      if (cyc < hist_n) begin
         hist_tag[cyc] = tag_data;
         hist_bsy[cyc] = busy;
      end
      cyc++;
   end

   function automatic logic [63:0] slice(input int t0, input int n);
      logic [63:0] r = '0;
      for (int i = 0; i < n; i++) r = {r[62:0], hist_tag[t0 + i]};
      return r;
   endfunction

   task automatic send(input bit op, input logic [lg_els-1:0] node, input logic dnr,
                       input logic [tag_lg_width_p-1:0] len, input logic [pw-1:0] pay,
                       output int t0);
      bit got = 1'b0;
      cmd_if.op_i             = op ? e_tag_op_master_reset : e_tag_op_packet;
      cmd_if.node_id_i        = node;
      cmd_if.data_not_reset_i = dnr;
      cmd_if.len_i            = len;
      cmd_if.payload_i        = pay;
      cmd_if.v_i              = 1'b1;
      for (int n = 0; n < 400 && !got; n++) begin
         @(negedge clk);
         got = cmd_if.ready_o;
      end
      chk("accept_within_budget", 64'(got), 64'd1);
      @(posedge clk);
      #1;
      t0 = cyc;
      cmd_if.v_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "watchdog");
   end

   initial begin
      int ta, tb, tm, tc, td, te, tf;
      cmd_if.op_i             = e_tag_op_packet;
      cmd_if.node_id_i        = 10'd5;
      cmd_if.data_not_reset_i = 1'b1;
      cmd_if.len_i            = 4'd1;
      cmd_if.payload_i        = 15'd1;
      cmd_if.v_i              = 1'b1;

      // Pin the model's packet builder to hand-derived streams.
      gen(1'b0, 10'd5, 1'b1, 4'd1, 15'd1);
      chk("model_len_a", 64'(gq.size()), 64'(17 + gap_c));
      chk("model_bits_a", pack_gq(17), 64'(17'b1_1010000000_1_1000_1));
      gen(1'b0, 10'd0, 1'b0, 4'd0, 15'h7fff);
      chk("model_len_zero", 64'(gq.size()), 64'(16 + gap_c));
      chk("model_bits_zero", pack_gq(16), 64'(16'h8000));
      gen(1'b1, 10'd0, 1'b0, 4'd0, 15'd0);
      chk("model_len_mreset", 64'(gq.size()), 64'(reset_ones_p + gap_c));

      repeat (3) @(negedge clk);
      chk("ready_in_reset", 64'(cmd_if.ready_o), 64'd0);
      chk("tag_in_reset", 64'(tag_data), 64'd0);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      chk("ready_after_release", 64'(cmd_if.ready_o), 64'd1);

      send(1'b0, 10'd5, 1'b1, 4'd1, 15'd1, ta);
      repeat (25) @(negedge clk);
      chk("pkt_a_bits", slice(ta, 17), 64'(17'b1_1010000000_1_1000_1));
      chk("pkt_a_idle_before", 64'(hist_tag[ta - 1]), 64'd0);
      chk("pkt_a_zero_after", 64'(hist_tag[ta + 17]), 64'd0);
      chk("pkt_a_busy_last", 64'(hist_bsy[ta + 16]), 64'd1);
      chk("pkt_a_busy_after", 64'(hist_bsy[ta + 17 + gap_c]), 64'd0);

      send(1'b0, 10'd0, 1'b0, 4'd0, 15'h7fff, tb);
      repeat (22) @(negedge clk);
      chk("len0_bits", slice(tb, 17), 64'(17'b1_0000000000_0_0000_0));
      chk("len0_busy_last", 64'(hist_bsy[tb + 15]), 64'd1);
      chk("len0_busy_after", 64'(hist_bsy[tb + 16 + gap_c]), 64'd0);

      send(1'b1, 10'd0, 1'b0, 4'd0, 15'd0, tm);
      repeat (40) @(negedge clk);
      chk("mreset_ones", slice(tm, 32), 64'hffff_ffff);
      chk("mreset_zero_after", 64'(hist_tag[tm + 32]), 64'd0);
      chk("mreset_idle_before", 64'(hist_tag[tm - 1]), 64'd0);

      // Back-to-back with v_i held: next accept on the first idle cycle.
      send(1'b0, 10'h3ff, 1'b1, 4'd3, 15'h5, tc);
      send(1'b0, 10'h2aa, 1'b0, 4'd2, 15'h3, td);
      chk("b2b_spacing", 64'(td - tc), 64'(19 + 1 + gap_c));
      repeat (25) @(negedge clk);
      chk("b2b_c_bits", slice(tc, 19), 64'(19'b1_1111111111_1_1100_101));
      chk("b2b_d_bits", slice(td, 18), 64'(18'b1_0101010101_0_0100_11));

      // Reset in the middle of a payload.
      send(1'b0, 10'd7, 1'b1, 4'd15, 15'h7fff, te);
      repeat (19) @(posedge clk);
      #2;
      chk("pre_reset_tag", 64'(tag_data), 64'd1);
      chk("pre_reset_busy", 64'(busy), 64'd1);
      reset_n = 1'b0;
      #1;
      chk("mid_reset_tag", 64'(tag_data), 64'd0);
      chk("mid_reset_busy", 64'(busy), 64'd0);
      chk("mid_reset_ready", 64'(cmd_if.ready_o), 64'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      send(1'b0, 10'd5, 1'b1, 4'd1, 15'd1, tf);
      repeat (25) @(negedge clk);
      chk("post_reset_bits", slice(tf, 17), 64'(17'b1_1010000000_1_1000_1));
      chk("post_reset_zero_after", 64'(hist_tag[tf + 17]), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
